// File: rtl/input_port_conditioner.sv
// Conditions NUM_PORTS raw external bytes: two-flop synchronizer, per-port debounce, change flags.
// Optional feature: define INPUT_PORT_IRQ_EN to get a registered irq while any change flag is set.
module input_port_conditioner #(
  parameter int          NUM_PORTS       = 16,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [7:0]  BASE_ADDR       = 8'hF0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [8*NUM_PORTS-1:0] raw_in,
  input  logic [7:0]             address,
  input  logic                   rd_strobe,
  output logic [8*NUM_PORTS-1:0] port_out,
  output logic [NUM_PORTS-1:0]   change_flags,
  output logic                   irq
);

  localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  logic [8*NUM_PORTS-1:0] sync1;
  logic [8*NUM_PORTS-1:0] sync2;
  logic [7:0]             cand [NUM_PORTS];
  logic [CW-1:0]          cnt  [NUM_PORTS];

  logic [NUM_PORTS-1:0]   commit;
  logic [NUM_PORTS-1:0]   flag_set;
  logic [NUM_PORTS-1:0]   flag_clr;
  logic [NUM_PORTS-1:0]   flags_next;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    commit     = '0;
    flag_set   = '0;
    flag_clr   = '0;
    flags_next = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      // Commit is the edge on which a stable candidate's count reaches DEBOUNCE_CYCLES.
      commit[i]     = (sync2[8*i +: 8] == cand[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
      flag_set[i]   = commit[i] && (cand[i] != port_out[8*i +: 8]);
      // 9-bit compare so the decode never wraps past 0xFF.
      flag_clr[i]   = rd_strobe && ({1'b0, address} == (9'(BASE_ADDR) + 9'(i)));
      flags_next[i] = flag_set[i] | (change_flags[i] & ~flag_clr[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1        <= '0;
      sync2        <= '0;
      port_out     <= '0;
      change_flags <= '0;
      // NOTE: these small per-port arrays are registers, not RAM, so they are reset like any flop.
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      sync1        <= raw_in;
      sync2        <= sync1;
      change_flags <= flags_next;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (sync2[8*i +: 8] != cand[i]) begin
          cand[i] <= sync2[8*i +: 8];
          cnt[i]  <= '0;
        end else if (cnt[i] < CW'(DEBOUNCE_CYCLES)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        if (commit[i]) port_out[8*i +: 8] <= cand[i];
      end
    end
  end

`ifdef INPUT_PORT_IRQ_EN
  always_ff @(posedge clock) begin
    if (reset) irq <= 1'b0;
    else       irq <= |flags_next;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_conditioner.sv
// Bench for input_port_conditioner: vector table, directed corner sequences and a randomized
// run compared against a history-based reference model.
module tb_input_port_conditioner;

  localparam int         NP   = 16;
  localparam int         D    = 4;
  localparam logic [7:0] BASE = 8'hF0;

  logic          clock = 1'b0;
  logic          reset;
  logic [127:0]  raw_in;
  logic [7:0]    address;
  logic          rd_strobe;
  logic [127:0]  port_out;
  logic [15:0]   change_flags;
  logic          irq;

  input_port_conditioner #(
    .NUM_PORTS       (NP),
    .DEBOUNCE_CYCLES (D),
    .BASE_ADDR       (BASE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .raw_in       (raw_in),
    .address      (address),
    .rd_strobe    (rd_strobe),
    .port_out     (port_out),
    .change_flags (change_flags),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic exp_irq(input logic [15:0] f);
`ifdef INPUT_PORT_IRQ_EN
    return |f;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: per port, the history of raw bytes seen at each edge. A byte commits on
  // edge n when the run of identical values ending two edges back is exactly D+1 long.
  // After reset the history is seeded with three zeros (sync1, sync2 and candidate contents).
  logic [7:0]  m_hist [NP][$];
  logic [7:0]  m_out  [NP];
  logic [15:0] m_flags;

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      m_hist[p].delete();
      repeat (3) m_hist[p].push_back(8'h00);
      m_out[p] = 8'h00;
    end
    m_flags = '0;
  endfunction

  function automatic void model_edge();
    logic [15:0] set_m;
    logic [15:0] clr_m;
    if (reset) begin
      model_reset();
      return;
    end
    set_m = '0;
    clr_m = '0;
    for (int p = 0; p < NP; p++) begin
      int idx;
      int run;
      logic [7:0] v;
      m_hist[p].push_back(raw_in[8*p +: 8]);
      if (m_hist[p].size() > D + 4) void'(m_hist[p].pop_front());
      idx = m_hist[p].size() - 3;
      v   = m_hist[p][idx];
      run = 1;
      for (int k = idx - 1; k >= 0; k--) begin
        if (m_hist[p][k] == v) run++;
        else break;
      end
      if (run == D + 1) begin
        if (v != m_out[p]) set_m[p] = 1'b1;
        m_out[p] = v;
      end
    end
    if (rd_strobe && address >= BASE && (int'(address) - int'(BASE)) < NP)
      clr_m[address - BASE] = 1'b1;
    m_flags = (m_flags & ~clr_m) | set_m;
  endfunction

  function automatic logic [127:0] model_out();
    logic [127:0] r;
    r = '0;
    for (int p = 0; p < NP; p++) r[8*p +: 8] = m_out[p];
    return r;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rd_strobe = 1'b0;
    address   = 8'h00;
    raw_in    = '0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
  endtask

  typedef struct {
    logic        rst;
    logic [7:0]  raw3;
    logic        rd;
    logic [7:0]  addr;
    logic [7:0]  exp_out3;
    logic [15:0] exp_flags;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl = '{
      '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 16'h0000},
      '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 16'h0000},
      '{1'b0, 8'h3C, 1'b0, 8'h00, 8'h00, 16'h0000},  // edge 0
      '{1'b0, 8'h3C, 1'b0, 8'h00, 8'h00, 16'h0000},
      '{1'b0, 8'h3C, 1'b0, 8'h00, 8'h00, 16'h0000},
      '{1'b0, 8'h3C, 1'b0, 8'h00, 8'h00, 16'h0000},
      '{1'b0, 8'h3C, 1'b0, 8'h00, 8'h00, 16'h0000},
      '{1'b0, 8'h3C, 1'b0, 8'h00, 8'h00, 16'h0000},  // edge 5: not yet
      '{1'b0, 8'h3C, 1'b0, 8'h00, 8'h3C, 16'h0008},  // edge 6: commit
      '{1'b0, 8'h3C, 1'b1, 8'hF2, 8'h3C, 16'h0008},
      '{1'b0, 8'h3C, 1'b1, 8'h90, 8'h3C, 16'h0008},
      '{1'b0, 8'h3C, 1'b1, 8'hF3, 8'h3C, 16'h0000},
      '{1'b0, 8'h3C, 1'b0, 8'h00, 8'h3C, 16'h0000}
    };

    reset     = 1'b1;
    rd_strobe = 1'b0;
    address   = 8'h00;
    raw_in    = {16{8'hA5}};

    // Reset holds everything at zero, then all ports commit 0xA5 on edge 6 after release.
    repeat (3) tick();
    check("reset_port_out", port_out, '0);
    check("reset_flags", {112'b0, change_flags}, '0);
    check("reset_irq", {127'b0, irq}, '0);
    reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) check("a5_not_early", {120'b0, port_out[7:0]}, 128'h00);
      if (e == 6) begin
        check("a5_commit", port_out, {16{8'hA5}});
        check("a5_flags", {112'b0, change_flags}, 128'hFFFF);
        check("a5_irq", {127'b0, irq}, {127'b0, exp_irq(16'hFFFF)});
      end
    end

    // Table: latency on port 3, read clear with matching and non-matching addresses.
    for (int r = 0; r < 13; r++) begin
      reset      = tbl[r].rst;
      raw_in     = '0;
      raw_in[31:24] = tbl[r].raw3;
      rd_strobe  = tbl[r].rd;
      address    = tbl[r].addr;
      tick();
      check($sformatf("tbl%0d_out3", r), {120'b0, port_out[31:24]}, {120'b0, tbl[r].exp_out3});
      check($sformatf("tbl%0d_flags", r), {112'b0, change_flags}, {112'b0, tbl[r].exp_flags});
      check($sformatf("tbl%0d_irq", r), {127'b0, irq}, {127'b0, exp_irq(tbl[r].exp_flags)});
    end
    rd_strobe = 1'b0;

    // Glitch of 3 cycles on port 5 is rejected; a 7-cycle pulse commits and then reverts.
    do_reset();
    for (int j = 0; j < 15; j++) begin
      raw_in[47:40] = (j < 3) ? 8'hFF : 8'h00;
      tick();
      check($sformatf("glitch3_out5_%0d", j), {120'b0, port_out[47:40]}, 128'h00);
      check($sformatf("glitch3_flag5_%0d", j), {127'b0, change_flags[5]}, 128'h0);
    end
    for (int j = 0; j < 20; j++) begin
      raw_in[47:40] = (j < 7) ? 8'hFF : 8'h00;
      tick();
      check($sformatf("pulse7_out5_%0d", j), {120'b0, port_out[47:40]},
            {120'b0, ((j >= 6 && j < 13) ? 8'hFF : 8'h00)});
      check($sformatf("pulse7_flag5_%0d", j), {127'b0, change_flags[5]}, {127'b0, (j >= 6)});
    end

    // Read of 0xF7 on the very edge port 7 commits: set wins; next read clears.
    do_reset();
    for (int j = 0; j < 8; j++) begin
      raw_in[63:56] = 8'h11;
      rd_strobe     = (j >= 6);
      address       = 8'hF7;
      tick();
      if (j == 6) begin
        check("collide_out7", {120'b0, port_out[63:56]}, 128'h11);
        check("collide_flags", {112'b0, change_flags}, 128'h0080);
        check("collide_irq", {127'b0, irq}, {127'b0, exp_irq(16'h0080)});
      end
      if (j == 7) begin
        check("reread_flags", {112'b0, change_flags}, 128'h0);
        check("reread_irq", {127'b0, irq}, {127'b0, exp_irq(16'h0000)});
      end
    end
    rd_strobe = 1'b0;

    // Reset while port 1's count is at 2 discards the debounce; a full 6 edges follow.
    do_reset();
    raw_in[15:8] = 8'h5A;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("middeb_reset_out", port_out, '0);
    check("middeb_reset_flags", {112'b0, change_flags}, '0);
    reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 5) check("middeb_not_early", {120'b0, port_out[15:8]}, 128'h00);
      if (e == 6) begin
        check("middeb_commit", {120'b0, port_out[15:8]}, 128'h5A);
        check("middeb_flags", {112'b0, change_flags}, 128'h0002);
      end
    end

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 5) == 0) raw_in[8*p +: 8] = 8'($urandom);
      rd_strobe = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) address = 8'($urandom);
      else                           address = BASE + 8'($urandom_range(0, NP - 1));
      tick();
      check($sformatf("rand%0d_out", c), port_out, model_out());
      check($sformatf("rand%0d_flags", c), {112'b0, change_flags}, {112'b0, m_flags});
      check($sformatf("rand%0d_irq", c), {127'b0, irq}, {127'b0, exp_irq(m_flags)});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
